// File: rtl/cache_refill_controller_if.sv
// Processor-request, tag-lookup and memory-word signals between the cache datapath and its refill controller.
// The slave modport is the controller; the master modport is the cache/memory side that drives it.
interface cache_refill_controller_if #(
  parameter int TAG_WIDTH    = 24,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAYS         = 2
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = OFFSET_WIDTH - 2;

  logic                 en_i;
  logic                 write_en_i;
  logic [31:0]          addr_i;
  logic                 hit_i;
  logic [WAY_W-1:0]     hit_way_i;
  logic [WAYS-1:0]      valid_i;
  logic [WAYS-1:0]      dirty_i;
  logic [TAG_WIDTH-1:0] tag_victim_i;
  logic                 mem_ready_i;

  logic                 mem_req_o;
  logic                 mem_write_en_o;
  logic [31:0]          mem_addr_o;
  logic [WAY_W-1:0]     way_sel_o;
  logic [WAY_W-1:0]     victim_way_o;
  logic                 line_write_o;
  logic                 set_valid_o;
  logic                 set_dirty_o;
  logic [LINE_W-1:0]    offset_line_o;
  logic                 stall_o;

  modport master (
    output en_i, write_en_i, addr_i, hit_i, hit_way_i, valid_i, dirty_i, tag_victim_i, mem_ready_i,
    input  mem_req_o, mem_write_en_o, mem_addr_o, way_sel_o, victim_way_o, line_write_o,
           set_valid_o, set_dirty_o, offset_line_o, stall_o
  );

  modport slave (
    input  en_i, write_en_i, addr_i, hit_i, hit_way_i, valid_i, dirty_i, tag_victim_i, mem_ready_i,
    output mem_req_o, mem_write_en_o, mem_addr_o, way_sel_o, victim_way_o, line_write_o,
           set_valid_o, set_dirty_o, offset_line_o, stall_o
  );
endinterface

// File: rtl/cache_refill_controller.sv
// Set-associative cache miss handler: victim pick, optional dirty write-back, then line refill, one word per memory beat.
// Hits complete combinationally; misses stall the requester until the refill ends, and mem_ready_i=0 freezes all progress.
module cache_refill_controller #(
  parameter int TAG_WIDTH    = 24,
  parameter int SET_WIDTH    = 3,
  parameter int OFFSET_WIDTH = 5,
  parameter int WAYS         = 2
) (
  input logic                    clk_i,
  input logic                    rst_i,
  cache_refill_controller_if.slave bus
);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int LINE_W = OFFSET_WIDTH - 2;
  localparam int NSETS  = 2 ** SET_WIDTH;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, REFILL} state_t;

  state_t               state_q, state_d;
  logic [LINE_W-1:0]    cnt_q, cnt_d;
  logic [WAY_W-1:0]     victim_q;
  logic [TAG_WIDTH-1:0] victim_tag_q;
  logic                 victim_from_rr_q;
  logic [WAY_W-1:0]     rr_q [NSETS];

  logic [TAG_WIDTH-1:0] req_tag;
  logic [SET_WIDTH-1:0] req_set;
  logic [LINE_W-1:0]    req_word;
  logic [1:0]           unused_addr_bits;

  assign req_tag          = bus.addr_i[31 -: TAG_WIDTH];
  assign req_set          = bus.addr_i[31-TAG_WIDTH -: SET_WIDTH];
  assign req_word         = bus.addr_i[OFFSET_WIDTH-1:2];
  assign unused_addr_bits = bus.addr_i[1:0];

  // Lowest invalid way wins; the round-robin pointer only matters when the set is full.
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] victim_sel;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!bus.valid_i[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign victim_sel = inv_found ? inv_way : rr_q[req_set];

  logic              latch_victim;
  logic              rr_adv;
  logic              mem_req, mem_we, line_write, set_valid, set_dirty, stall;
  logic [31:0]       mem_addr;
  logic [WAY_W-1:0]  way_sel, victim_way;
  logic [LINE_W-1:0] offset_line;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      victim_q         <= '0;
      victim_tag_q     <= '0;
      victim_from_rr_q <= 1'b0;
      for (int s = 0; s < NSETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch_victim) begin
        victim_q         <= victim_sel;
        victim_tag_q     <= bus.tag_victim_i;
        victim_from_rr_q <= ~inv_found;
      end
      if (rr_adv) rr_q[req_set] <= rr_q[req_set] + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    latch_victim = 1'b0;
    rr_adv       = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {req_tag, req_set, cnt_q, 2'b00};
    way_sel      = victim_q;
    victim_way   = victim_q;
    line_write   = 1'b0;
    set_valid    = 1'b0;
    set_dirty    = 1'b0;
    offset_line  = cnt_q;
    stall        = 1'b0;

    case (state_q)
      IDLE: begin
        victim_way  = victim_sel;
        way_sel     = victim_sel;
        offset_line = req_word;
        if (bus.en_i) begin
          if (bus.hit_i) begin
            way_sel    = bus.hit_way_i;
            line_write = bus.write_en_i;
            set_dirty  = bus.write_en_i;
            set_valid  = bus.write_en_i;
          end else begin
            stall        = 1'b1;
            latch_victim = 1'b1;
            cnt_d        = '0;
            state_d      = (bus.dirty_i[victim_sel] && bus.valid_i[victim_sel]) ? WRITE_BACK : REFILL;
          end
        end
      end
      WRITE_BACK: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = {victim_tag_q, req_set, cnt_q, 2'b00};
        stall    = 1'b1;
        if (bus.mem_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req    = 1'b1;
        stall      = 1'b1;
        line_write = bus.mem_ready_i;
        if (bus.mem_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            cnt_d     = '0;
            set_valid = 1'b1;
            rr_adv    = victim_from_rr_q;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset quiets the memory and array strobes immediately, not just from the next edge.
    if (rst_i) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      line_write = 1'b0;
      set_valid  = 1'b0;
      set_dirty  = 1'b0;
      stall      = 1'b0;
    end
  end

  assign bus.mem_req_o      = mem_req;
  assign bus.mem_write_en_o = mem_we;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.way_sel_o      = way_sel;
  assign bus.victim_way_o   = victim_way;
  assign bus.line_write_o   = line_write;
  assign bus.set_valid_o    = set_valid;
  assign bus.set_dirty_o    = set_dirty;
  assign bus.offset_line_o  = offset_line;
  assign bus.stall_o        = stall;
endmodule

// File: tb/tb_cache_refill_controller.sv
// Scoreboard bench for cache_refill_controller: expected memory beats are queued per miss and
// popped by a monitor whenever the DUT completes a beat; hit, victim and reset behaviour checked directly.
module tb_cache_refill_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cache_refill_controller_if #(.TAG_WIDTH(24), .OFFSET_WIDTH(5), .WAYS(2)) bus ();

  cache_refill_controller #(
    .TAG_WIDTH(24), .SET_WIDTH(3), .OFFSET_WIDTH(5), .WAYS(2)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    n_chk = 0;
  int    n_err = 0;
  int    beats_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && bus.mem_req_o && bus.mem_ready_i) begin
      beats_seen++;
      if (exp_q.size() == 0) begin
        check("beat_unexpected", 32'd1, 32'd0);
      end else begin
        mon_b = exp_q.pop_front();
        check("beat_addr", bus.mem_addr_o, mon_b.addr);
        check("beat_dir", {31'd0, bus.mem_write_en_o}, {31'd0, mon_b.we});
      end
    end
  end

  task automatic idle_inputs();
    bus.en_i         = 1'b0;
    bus.write_en_i   = 1'b0;
    bus.addr_i       = 32'h0;
    bus.hit_i        = 1'b0;
    bus.hit_way_i    = 1'b0;
    bus.valid_i      = 2'b11;
    bus.dirty_i      = 2'b00;
    bus.tag_victim_i = 24'h0;
    bus.mem_ready_i  = 1'b0;
  endtask

  task automatic peek_victim(input string tag, input logic [31:0] addr, input logic exp_way);
    @(posedge clk); #2;
    bus.en_i    = 1'b0;
    bus.addr_i  = addr;
    bus.valid_i = 2'b11;
    @(negedge clk);
    check(tag, {31'd0, bus.victim_way_o}, {31'd0, exp_way});
    check({tag, "_quiet"}, {31'd0, bus.stall_o}, 32'd0);
  endtask

  task automatic run_miss(input logic [31:0] addr, input logic [1:0] valid, input logic [1:0] dirty,
                          input logic [23:0] vtag, input logic exp_victim, input bit exp_wb,
                          input bit toggle);
    int         lw = 0;
    int         cyc = 0;
    int         base;
    bit         done = 0;
    bit         prev_ready = 1;
    logic [2:0] prev_off = '0;
    base = beats_seen;
    if (exp_wb)
      for (int k = 0; k < 8; k++) exp_q.push_back({1'b1, vtag, addr[7:5], 3'(k), 2'b00});
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, addr[31:5], 3'(k), 2'b00});

    @(posedge clk); #2;
    bus.en_i         = 1'b1;
    bus.write_en_i   = 1'b0;
    bus.addr_i       = addr;
    bus.hit_i        = 1'b0;
    bus.valid_i      = valid;
    bus.dirty_i      = dirty;
    bus.tag_victim_i = vtag;
    bus.mem_ready_i  = 1'b0;
    @(negedge clk);
    check("miss_stall", {31'd0, bus.stall_o}, 32'd1);
    check("miss_victim", {31'd0, bus.victim_way_o}, {31'd0, exp_victim});
    check("miss_no_req", {31'd0, bus.mem_req_o}, 32'd0);

    while (!done && cyc < 100) begin
      @(posedge clk); #2;
      cyc++;
      // The en_i drop mid-transfer must not abort the line.
      if (cyc == 3) bus.en_i = 1'b0;
      bus.mem_ready_i = toggle ? (cyc % 3 == 1) : 1'b1;
      @(negedge clk);
      lw += int'(bus.line_write_o);
      if (bus.mem_req_o && !bus.mem_ready_i && !prev_ready)
        check("wait_hold", {29'd0, bus.offset_line_o}, {29'd0, prev_off});
      prev_ready = bus.mem_ready_i;
      prev_off   = bus.offset_line_o;
      if (bus.set_valid_o) begin
        done = 1;
        check("final_offset", {29'd0, bus.offset_line_o}, 32'd7);
        check("final_way", {31'd0, bus.way_sel_o}, {31'd0, exp_victim});
      end
    end
    if (!done) check("refill_timeout", 32'd0, 32'd1);

    @(posedge clk); #2;
    bus.en_i        = 1'b1;
    bus.hit_i       = 1'b1;
    bus.hit_way_i   = exp_victim;
    bus.mem_ready_i = 1'b0;
    @(negedge clk);
    check("stall_drop", {31'd0, bus.stall_o}, 32'd0);
    check("done_no_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("line_writes", lw, 8);
    check("beat_count", beats_seen - base, exp_wb ? 16 : 8);
    check("queue_empty", exp_q.size(), 0);
    @(posedge clk); #2;
    idle_inputs();
  endtask

  initial begin
    bit found = 0;
    rst = 1'b1;
    idle_inputs();
    bus.en_i = 1'b1;
    #3;
    check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("rst_set_valid", {31'd0, bus.set_valid_o}, 32'd0);
    bus.en_i = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, bus.stall_o}, 32'd0);
    check("idle_line_write", {31'd0, bus.line_write_o}, 32'd0);

    // Store hit way 1
    @(posedge clk); #2;
    bus.en_i = 1'b1; bus.write_en_i = 1'b1; bus.hit_i = 1'b1; bus.hit_way_i = 1'b1;
    bus.addr_i = 32'h0000_0124;
    @(negedge clk);
    check("st_line_write", {31'd0, bus.line_write_o}, 32'd1);
    check("st_set_dirty", {31'd0, bus.set_dirty_o}, 32'd1);
    check("st_way_sel", {31'd0, bus.way_sel_o}, 32'd1);
    check("st_stall", {31'd0, bus.stall_o}, 32'd0);
    check("st_offset", {29'd0, bus.offset_line_o}, 32'd1);
    check("st_no_req", {31'd0, bus.mem_req_o}, 32'd0);

    // Load hit way 0
    @(posedge clk); #2;
    bus.write_en_i = 1'b0; bus.hit_way_i = 1'b0;
    @(negedge clk);
    check("ld_line_write", {31'd0, bus.line_write_o}, 32'd0);
    check("ld_way_sel", {31'd0, bus.way_sel_o}, 32'd0);
    check("ld_stall", {31'd0, bus.stall_o}, 32'd0);
    @(posedge clk); #2;
    idle_inputs();

    run_miss(32'h0000_0124, 2'b11, 2'b00, 24'h000001, 1'b0, 1'b0, 1'b0);
    peek_victim("rr_other_set", 32'h0000_0144, 1'b0);
    peek_victim("rr_set1_adv", 32'h0000_0124, 1'b1);
    run_miss(32'h0000_0124, 2'b11, 2'b10, 24'hABCDEF, 1'b1, 1'b1, 1'b0);
    peek_victim("rr_set1_wrap", 32'h0000_0124, 1'b0);
    run_miss(32'h0000_0124, 2'b10, 2'b00, 24'h111111, 1'b0, 1'b0, 1'b1);
    peek_victim("rr_set1_hold", 32'h0000_0124, 1'b0);

    // Reset between edges during refill beat 3
    for (int k = 0; k < 8; k++) exp_q.push_back({1'b0, 24'h000001, 3'd1, 3'(k), 2'b00});
    @(posedge clk); #2;
    bus.en_i = 1'b1; bus.addr_i = 32'h0000_0124; bus.valid_i = 2'b11; bus.mem_ready_i = 1'b1;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.mem_req_o && !bus.mem_write_en_o && bus.offset_line_o == 3'd3) found = 1;
    end
    if (!found) check("rst_beat3_timeout", 32'd0, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("midrst_mem_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("midrst_stall", {31'd0, bus.stall_o}, 32'd0);
    #1 rst = 1'b0;
    #1;
    check("postrst_idle_req", {31'd0, bus.mem_req_o}, 32'd0);
    check("postrst_idle_stall", {31'd0, bus.stall_o}, 32'd1);
    exp_q.delete();
    bus.en_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("postrst_quiet", {31'd0, bus.mem_req_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
